// File: rtl/apb_slave_decoder.sv
// APB fan-out decoder: routes one upstream APB master to NO_OF_SLAVES address regions,
// answering unmapped, timed-out and malformed accesses itself and counting them.
module apb_slave_decoder #(
   parameter int NO_OF_SLAVES    = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int SLAVE_SPAN_LOG2 = 12,
   parameter int TIMEOUT_CYCLES  = 16
) (
   input  logic                               pclk,
   input  logic                               preset,
   input  logic                               psel,
   input  logic                               penable,
   input  logic                               pwrite,
   input  logic [ADDR_WIDTH-1:0]              paddr,
   input  logic [DATA_WIDTH-1:0]              pwdata,
   input  logic [DATA_WIDTH/8-1:0]            pstrb,
   input  logic [2:0]                         pprot,
   output logic [DATA_WIDTH-1:0]              prdata,
   output logic                               pready,
   output logic                               pslverr,
   output logic [NO_OF_SLAVES-1:0]            psel_s,
   output logic                               penable_s,
   output logic [ADDR_WIDTH-1:0]              paddr_s,
   output logic                               pwrite_s,
   output logic [DATA_WIDTH-1:0]              pwdata_s,
   output logic [DATA_WIDTH/8-1:0]            pstrb_s,
   output logic [2:0]                         pprot_s,
   input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] prdata_s,
   input  logic [NO_OF_SLAVES-1:0]            pready_s,
   input  logic [NO_OF_SLAVES-1:0]            pslverr_s,
   output logic [7:0]                         err_count,
   output logic [1:0]                         last_err_code
);
   localparam int IW = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
   localparam int HI = SLAVE_SPAN_LOG2 + IW;
   localparam logic [IW:0] NS = NO_OF_SLAVES[IW:0];
   localparam logic [7:0] TO = TIMEOUT_CYCLES[7:0];

   typedef enum logic [1:0] {IDLE, ACCESS, ERR_RESP} state_t;

   state_t state, state_n;
   logic [IW-1:0] dec_idx, idx_q;
   logic dec_mapped, mapped_q, hi_set, latch;
   logic [7:0] cnt, cnt_n;
   logic err_evt;
   logic [1:0] err_code;
   logic [NO_OF_SLAVES-1:0] dec_onehot, acc_onehot;
   logic [NO_OF_SLAVES-1:0][DATA_WIDTH-1:0] rdata_arr;

   assign paddr_s  = paddr;
   assign pwrite_s = pwrite;
   assign pwdata_s = pwdata;
   assign pstrb_s  = pstrb;
   assign pprot_s  = pprot;

   assign dec_idx = paddr[SLAVE_SPAN_LOG2 +: IW];
   // Any address bit above the slave-index field lands outside every region.
   generate
      if (HI < ADDR_WIDTH) begin : g_hi
         assign hi_set = |paddr[ADDR_WIDTH-1:HI];
      end else begin : g_nohi
         assign hi_set = 1'b0;
      end
   endgenerate
   assign dec_mapped = !hi_set && ({1'b0, dec_idx} < NS);

   assign rdata_arr = prdata_s;
   generate
      for (genvar i = 0; i < NO_OF_SLAVES; i++) begin : g_sel
         assign dec_onehot[i] = (dec_idx == IW'(i));
         assign acc_onehot[i] = (idx_q == IW'(i));
      end
   endgenerate

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state         <= IDLE;
         idx_q         <= '0;
         mapped_q      <= 1'b0;
         cnt           <= '0;
         err_count     <= '0;
         last_err_code <= 2'b00;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (latch) begin
            idx_q    <= dec_idx;
            mapped_q <= dec_mapped;
         end
         if (err_evt) begin
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            last_err_code <= err_code;
         end
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      latch     = 1'b0;
      err_evt   = 1'b0;
      err_code  = 2'b00;
      psel_s    = '0;
      penable_s = 1'b0;
      pready    = 1'b0;
      pslverr   = 1'b0;
      prdata    = '0;
      if (!preset) begin
         case (state)
            IDLE: begin
               cnt_n = '0;
               if (psel && !penable) begin
                  latch   = 1'b1;
                  psel_s  = dec_mapped ? dec_onehot : '0;
                  state_n = ACCESS;
               end else if (psel && penable) begin
                  pready   = 1'b1;
                  pslverr  = 1'b1;
                  err_evt  = 1'b1;
                  err_code = 2'b11;
               end
            end
            ACCESS: begin
               if (!psel) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else if (!mapped_q) begin
                  pready   = 1'b1;
                  pslverr  = 1'b1;
                  err_evt  = 1'b1;
                  err_code = 2'b01;
                  state_n  = IDLE;
               end else begin
                  psel_s    = acc_onehot;
                  penable_s = penable;
                  pready    = pready_s[idx_q];
                  pslverr   = pslverr_s[idx_q];
                  prdata    = rdata_arr[idx_q];
                  // A slave answering on the last allowed cycle beats the timeout.
                  if (pready_s[idx_q]) begin
                     state_n = IDLE;
                     cnt_n   = '0;
                  end else begin
                     cnt_n = cnt + 8'd1;
                     if (cnt_n == TO) state_n = ERR_RESP;
                  end
               end
            end
            ERR_RESP: begin
               pready   = 1'b1;
               pslverr  = 1'b1;
               err_evt  = 1'b1;
               err_code = 2'b10;
               cnt_n    = '0;
               state_n  = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_slave_decoder.sv
// Randomized bench for apb_slave_decoder: each transfer's outcome is predicted from the
// address map, the planned slave wait count and the timeout limit.
module tb_apb_slave_decoder;
   localparam int NS = 4;
   localparam int TO = 16;

   logic pclk = 1'b0;
   logic preset, psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata;
   logic [3:0] pstrb;
   logic [2:0] pprot;
   logic pready, pslverr, penable_s, pwrite_s;
   logic [NS-1:0] psel_s, pready_s, pslverr_s;
   logic [31:0] paddr_s, pwdata_s;
   logic [3:0] pstrb_s;
   logic [2:0] pprot_s;
   logic [NS*32-1:0] prdata_s;
   logic [7:0] err_count;
   logic [1:0] last_err_code;

   int checks = 0;
   int errors = 0;
   int m_cnt = 0;
   int m_code = 0;

   apb_slave_decoder #(.NO_OF_SLAVES(NS), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                       .SLAVE_SPAN_LOG2(12), .TIMEOUT_CYCLES(TO)) dut (
      .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .psel_s(psel_s), .penable_s(penable_s), .paddr_s(paddr_s), .pwrite_s(pwrite_s),
      .pwdata_s(pwdata_s), .pstrb_s(pstrb_s), .pprot_s(pprot_s),
      .prdata_s(prdata_s), .pready_s(pready_s), .pslverr_s(pslverr_s),
      .err_count(err_count), .last_err_code(last_err_code));

   always #5 pclk = ~pclk;

   // Region number is the address divided by the 4 KiB span; beyond NS it is unmapped.
   function automatic int slot_of(input logic [31:0] a);
      if ((a / 32'd4096) < NS) return int'(a / 32'd4096);
      return -1;
   endfunction

   task automatic note_err(input int code);
      m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
      m_code = code;
   endtask

   task automatic scramble_slaves();
      pready_s  = 4'($urandom);
      pslverr_s = 4'($urandom);
      for (int i = 0; i < NS; i++) prdata_s[i*32 +: 32] = $urandom;
   endtask

   // One full transfer: setup then access until the model says it completes.
   task automatic xfer(input logic [31:0] a, input logic wr, input int waits,
                       input logic serr, input logic [31:0] d);
      int s;
      logic [NS-1:0] e_sel;
      logic e_rdy, e_err, e_en;
      logic [31:0] e_data;
      bit done;
      s = slot_of(a);
      e_sel = (s >= 0) ? NS'(1 << s) : '0;
      done = 0;
      @(posedge pclk); #1;
      psel = 1; penable = 0; paddr = a; pwrite = wr; pwdata = $urandom;
      pstrb = 4'($urandom); pprot = 3'($urandom);
      scramble_slaves();
      @(negedge pclk);
      checks++;
      if (psel_s !== e_sel || pready !== 1'b0 || penable_s !== 1'b0 || paddr_s !== a ||
          pwdata_s !== pwdata || err_count !== m_cnt[7:0] || last_err_code !== m_code[1:0]) begin
         errors++;
         $display("FAIL setup a=%h: psel_s=%b pready=%b penable_s=%b paddr_s=%h err_count=%0d code=%0d, want psel_s=%b pready=0 penable_s=0 paddr_s=%h err_count=%0d code=%0d",
                  a, psel_s, pready, penable_s, paddr_s, err_count, last_err_code, e_sel, a, m_cnt, m_code);
      end
      for (int k = 0; k <= TO && !done; k++) begin
         @(posedge pclk); #1;
         penable = 1;
         scramble_slaves();
         if (s >= 0) begin
            pready_s[s]  = (k == waits);
            pslverr_s[s] = (k == waits) ? serr : 1'b0;
            prdata_s[s*32 +: 32] = d;
         end
         @(negedge pclk);
         if (s < 0) begin
            e_rdy = 1; e_err = 1; e_data = '0; e_sel = '0; e_en = 0; done = 1; note_err(1);
         end else if (k < TO && k == waits) begin
            e_rdy = 1; e_err = serr; e_data = d; e_en = 1; done = 1;
         end else if (k < TO) begin
            e_rdy = 0; e_err = 0; e_data = '0; e_en = 1;
         end else begin
            e_rdy = 1; e_err = 1; e_data = '0; e_sel = '0; e_en = 0; done = 1; note_err(2);
         end
         checks++;
         if (pready !== e_rdy || pslverr !== e_err || psel_s !== e_sel || penable_s !== e_en ||
             (e_rdy && prdata !== e_data)) begin
            errors++;
            $display("FAIL access a=%h k=%0d: pready=%b pslverr=%b psel_s=%b penable_s=%b prdata=%h, want %b %b %b %b %h",
                     a, k, pready, pslverr, psel_s, penable_s, prdata, e_rdy, e_err, e_sel, e_en, e_data);
         end
      end
   endtask

   task automatic idle_cycle();
      @(posedge pclk); #1;
      psel = 0; penable = 0;
      scramble_slaves();
      @(negedge pclk);
      checks++;
      if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== '0 || psel_s !== '0 ||
          err_count !== m_cnt[7:0] || last_err_code !== m_code[1:0]) begin
         errors++;
         $display("FAIL idle: pready=%b pslverr=%b prdata=%h psel_s=%b err_count=%0d code=%0d, want 0 0 0 0 %0d %0d",
                  pready, pslverr, prdata, psel_s, err_count, last_err_code, m_cnt, m_code);
      end
   endtask

   task automatic test_reset();
      preset = 1; psel = 1; penable = 0; paddr = 32'h2000; pwrite = 0;
      pwdata = '0; pstrb = '0; pprot = '0;
      scramble_slaves();
      #12;
      checks++;
      if (psel_s !== '0 || penable_s !== 1'b0 || pready !== 1'b0 || pslverr !== 1'b0 ||
          prdata !== '0 || err_count !== 8'd0 || last_err_code !== 2'b00) begin
         errors++;
         $display("FAIL reset: psel_s=%b penable_s=%b pready=%b pslverr=%b prdata=%h err_count=%0d code=%0d, want all 0",
                  psel_s, penable_s, pready, pslverr, prdata, err_count, last_err_code);
      end
      psel = 0;
      @(negedge pclk);
      preset = 0;
      idle_cycle();
   endtask

   task automatic test_write_slave2();
      xfer(32'h0000_2004, 1'b1, 0, 1'b0, 32'h1234_5678);
      idle_cycle();
   endtask

   task automatic test_read_waits();
      xfer(32'h0000_1010, 1'b0, 3, 1'b0, 32'hA5A5_5A5A);
      idle_cycle();
   endtask

   task automatic test_unmapped();
      xfer(32'h0000_5000, 1'b0, 0, 1'b0, 32'h0);
      idle_cycle();
   endtask

   task automatic test_timeout();
      xfer(32'h0000_0000, 1'b0, 99, 1'b0, 32'h0);
      idle_cycle();
      xfer(32'h0000_3008, 1'b0, TO - 1, 1'b1, 32'hCAFE_0001);
      idle_cycle();
   endtask

   task automatic test_protocol();
      @(posedge pclk); #1;
      psel = 1; penable = 1; paddr = 32'h0000_1000;
      for (int i = 0; i < 260; i++) begin
         @(negedge pclk);
         if (i == 0 || i == 100) begin
            checks++;
            if (pready !== 1'b1 || pslverr !== 1'b1 || prdata !== '0 || psel_s !== '0 ||
                err_count !== m_cnt[7:0]) begin
               errors++;
               $display("FAIL protocol i=%0d: pready=%b pslverr=%b prdata=%h psel_s=%b err_count=%0d, want 1 1 0 0 %0d",
                        i, pready, pslverr, prdata, psel_s, err_count, m_cnt);
            end
         end
         note_err(3);
         @(posedge pclk); #1;
      end
      psel = 0; penable = 0;
      @(negedge pclk);
      checks++;
      if (err_count !== 8'd255 || last_err_code !== 2'b11) begin
         errors++;
         $display("FAIL saturate: err_count=%0d code=%0d, want 255 3", err_count, last_err_code);
      end
      idle_cycle();
   endtask

   task automatic test_abort();
      @(posedge pclk); #1;
      psel = 1; penable = 0; paddr = 32'h0000_1000;
      @(posedge pclk); #1;
      penable = 1; pready_s = '0;
      @(posedge pclk); #1;
      psel = 0; penable = 0;
      @(negedge pclk);
      checks++;
      if (psel_s !== '0 || pready !== 1'b0 || pslverr !== 1'b0) begin
         errors++;
         $display("FAIL abort: psel_s=%b pready=%b pslverr=%b, want 0 0 0", psel_s, pready, pslverr);
      end
      idle_cycle();
   endtask

   task automatic test_reset_mid();
      @(posedge pclk); #1;
      psel = 1; penable = 0; paddr = 32'h0000_3000;
      @(posedge pclk); #1;
      penable = 1; pready_s = '0;
      @(posedge pclk); #2;
      preset = 1;
      #1;
      m_cnt = 0; m_code = 0;
      checks++;
      if (psel_s !== '0 || penable_s !== 1'b0 || pready !== 1'b0 || err_count !== 8'd0 ||
          last_err_code !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid: psel_s=%b penable_s=%b pready=%b err_count=%0d code=%0d, want all 0",
                  psel_s, penable_s, pready, err_count, last_err_code);
      end
      psel = 0; penable = 0;
      @(negedge pclk);
      preset = 0;
      xfer(32'h0000_3040, 1'b1, 1, 1'b0, 32'h0BAD_F00D);
      idle_cycle();
   endtask

   task automatic test_back_to_back();
      xfer(32'h0000_0010, 1'b0, 0, 1'b0, 32'h1111_1111);
      xfer(32'h0000_2020, 1'b1, 2, 1'b1, 32'h2222_2222);
      xfer(32'h0000_7000, 1'b0, 0, 1'b0, 32'h0);
      xfer(32'h0000_3030, 1'b0, 0, 1'b0, 32'h3333_3333);
      idle_cycle();
   endtask

   task automatic test_random();
      logic [31:0] a;
      int w;
      for (int n = 0; n < 40; n++) begin
         a = 32'($urandom_range(0, 5)) * 32'd4096 + 32'($urandom_range(0, 4095));
         if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(14, 31));
         w = ($urandom_range(0, 7) == 0) ? 17 : int'($urandom_range(0, 4));
         xfer(a, 1'($urandom), w, 1'($urandom), $urandom);
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end
      idle_cycle();
   endtask

   initial begin
      test_reset();
      test_write_slave2();
      test_read_waits();
      test_unmapped();
      test_timeout();
      test_protocol();
      test_reset_mid();
      test_abort();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/apb_slave_decoder.md
APB_SLAVE_DECODER -- requirements
Module: apb_slave_decoder

Interface
REQ-001 SHALL have parameter NO_OF_SLAVES, default 4, number of downstream slaves (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, APB data width (8/16/32).
REQ-004 SHALL have parameter SLAVE_SPAN_LOG2, default 12, log2 bytes per slave region.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16, max access-phase wait cycles before error (1..255).
REQ-006 SHALL have the decided clocking: one clock; reset is asynchronous and active-high.
REQ-007 pclk  input  1  APB clock, all state on rising edge.
REQ-008 preset  input  1  asynchronous active-high reset.
REQ-009 psel, penable, pwrite  input  1 each  upstream APB controls.
REQ-010 paddr  input  ADDR_WIDTH  upstream address; pwdata input DATA_WIDTH; pstrb input DATA_WIDTH/8; pprot input 3.
REQ-011 prdata  output  DATA_WIDTH; pready output 1; pslverr output 1  upstream response.
REQ-012 psel_s  output  NO_OF_SLAVES  one-hot downstream selects; penable_s output 1; paddr, pwrite, pwdata, pstrb, pprot forwarded unchanged.
REQ-013 prdata_s  input  NO_OF_SLAVES*DATA_WIDTH; pready_s input NO_OF_SLAVES; pslverr_s input NO_OF_SLAVES.
REQ-014 err_count  output  8  saturating count of decode, timeout and protocol errors.
REQ-015 last_err_code  output  2  00 none, 01 decode, 10 timeout, 11 protocol.

Function
REQ-016 Slave index = paddr[SLAVE_SPAN_LOG2 +: clog2(NO_OF_SLAVES)] (1 bit min); index >= NO_OF_SLAVES or any higher paddr bit set = unmapped.
REQ-017 FSM states IDLE, ACCESS, ERR_RESP; reset state IDLE.
REQ-018 IDLE: psel=1, penable=0 (setup) -> latch index, mapped flag -> ACCESS next cycle; psel_s one-hot combinationally in setup cycle when mapped.
REQ-019 ACCESS, mapped: psel_s held on latched index, penable_s = penable; pready/pslverr/prdata = selected slave's inputs; pready=1 -> IDLE.
REQ-020 ACCESS, unmapped: psel_s all 0; pready=1, pslverr=1, prdata=0 in first access cycle (zero wait); err_count++, last_err_code=01; -> IDLE.
REQ-021 Wait counter: cleared on entering ACCESS, +1 per access cycle with pready_s low; when counter == TIMEOUT_CYCLES -> ERR_RESP.
REQ-022 ERR_RESP: one cycle, psel_s all 0, pready=1, pslverr=1, prdata=0; err_count++, last_err_code=10; -> IDLE.
REQ-023 Slave pready_s in same cycle counter reaches limit: slave response wins, no timeout.
REQ-024 IDLE with psel=1, penable=1 (no setup): protocol error, pready=1, pslverr=1, prdata=0, no psel_s, last_err_code=11, err_count++.
REQ-025 ACCESS with psel dropped before pready: abort, psel_s=0, -> IDLE, no error counted.
REQ-026 Back-to-back: setup accepted in cycle after completion (IDLE), no bubble beyond APB protocol.
REQ-027 err_count saturates at 255; last_err_code holds until next error.
REQ-028 Outside a transfer pready=0, pslverr=0, prdata=0.

Reset
REQ-029 preset=1 asynchronously forces IDLE, psel_s=0, penable_s=0, pready=0, pslverr=0, prdata=0, counter=0, err_count=0, last_err_code=00.
REQ-030 Reset mid-ACCESS abandons transfer without error response; first setup after release handled normally.

Verification
REQ-031 Write paddr=0x0000_2004, slave 2 pready_s=1 first access cycle -> psel_s=0100 two cycles, pready=1, pslverr=0, err_count=0.
REQ-032 Read paddr=0x0000_1010, slave 1 prdata_s=0xA5A5_5A5A after 3 waits -> prdata=0xA5A5_5A5A, pready on 4th access cycle.
REQ-033 paddr=0x0000_5000 (NO_OF_SLAVES=4) -> psel_s=0000, pready=1, pslverr=1 first access cycle, err_count=1, last_err_code=01.
REQ-034 Slave 0 never ready, TIMEOUT_CYCLES=16 -> ERR_RESP after 16 wait cycles, pslverr=1, last_err_code=10.
REQ-035 penable=1 without setup -> pslverr=1, last_err_code=11; 256 errors -> err_count=255.
REQ-036 preset asserted during slave 3 wait -> psel_s=0 immediately, counters 0; next transfer completes cleanly.
